// File: rtl/regfile_write_buffer_pkg.sv
// regfile_write_buffer_pkg: shared widths and the queued writeback entry type
package regfile_write_buffer_pkg;
    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    typedef struct packed {
        logic [REG_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: finds the youngest valid queued entry whose register id matches i_reg
//   i_entries/i_valid/i_head : FIFO storage, valid mask and head pointer
//   i_reg                    : register id being read
//   o_hit/o_data             : match flag and data of the youngest match (0 when none)
module wb_fwd_match
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  wb_entry_t           i_entries [DEPTH],
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [PW-1:0]       i_head,
    input  logic [REG_ID_W-1:0] i_reg,
    output logic                o_hit,
    output logic [DATA_W-1:0]   o_data
);
    // Valid entries are contiguous from the head, so walking oldest to youngest
    // and letting later matches override leaves the youngest value.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_valid[i_head + PW'(i)] && i_entries[i_head + PW'(i)].id == i_reg) begin
                o_hit  = 1'b1;
                o_data = i_entries[i_head + PW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: FIFO of pending register file writes with read-port forwarding
//   wb_*        : writeback request handshake from the pipeline
//   rf_*        : register file write port, one entry drained per unstalled cycle
//   rd_reg1/2   : read port register ids; fwd_hit*/fwd_data* give queued values
//   count       : occupied entries
//   rst         : asynchronous, active-low
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter bit DROP_R0 = 1'b1,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [REG_ID_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                rf_stall,
    output logic                rf_WriteReg,
    output logic [REG_ID_W-1:0] rf_DstReg,
    output logic [DATA_W-1:0]   rf_DstData,
    input  logic [REG_ID_W-1:0] rd_reg1,
    input  logic [REG_ID_W-1:0] rd_reg2,
    output logic                fwd_hit1,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic                fwd_hit2,
    output logic [DATA_W-1:0]   fwd_data2,
    output logic [CW-1:0]       count
);
    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Ready ignores a same-cycle drain so it depends on registered state only.
    assign wb_ready    = rst & (r_count != CW'(DEPTH));
    // R0 writes complete the handshake but are never queued.
    assign w_push      = wb_valid & wb_ready & ~(DROP_R0 && wb_reg == '0);
    assign w_pop       = (r_count != '0) & ~rf_stall;
    assign rf_WriteReg = w_pop;
    assign rf_DstReg   = r_valid[r_head] ? r_mem[r_head].id   : '0;
    assign rf_DstData  = r_valid[r_head] ? r_mem[r_head].data : '0;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= '{id: wb_reg, data: wb_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .i_entries (r_mem),
        .i_valid   (r_valid),
        .i_head    (r_head),
        .i_reg     (rd_reg1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .i_entries (r_mem),
        .i_valid   (r_valid),
        .i_head    (r_head),
        .i_reg     (rd_reg2),
        .o_hit     (fwd_hit2),
        .o_data    (fwd_data2)
    );
endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-side front end for the 16x16 register file. Accepts writeback results from the pipeline over a valid/ready handshake and queues them in a small FIFO. Drains one entry per cycle into the register file write port (DstReg/WriteReg/DstData). Forwards the youngest pending value to both read ports, so reads never see stale data while writes are queued.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
DROP_R0, 1, writes to register 0 are accepted and discarded (R0 reads as zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_valid  in  1  writeback request valid
wb_ready  out  1  buffer can accept a request this cycle
wb_reg  in  4  destination register
wb_data  in  16  destination data
rf_stall  in  1  hold drain, no register file write this cycle
rf_WriteReg  out  1  register file write enable
rf_DstReg  out  4  register file write address
rf_DstData  out  16  register file write data
rd_reg1  in  4  read port 1 register id (same as register file SrcReg1)
rd_reg2  in  4  read port 2 register id (same as register file SrcReg2)
fwd_hit1  out  1  pending write matches rd_reg1
fwd_data1  out  16  forwarded value for rd_reg1
fwd_hit2  out  1  pending write matches rd_reg2
fwd_data2  out  16  forwarded value for rd_reg2
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, asynchronous): clear head/tail pointers and count, and invalidate all entries. Pending writes are discarded, including on a mid-operation reset.
- Output values while rst=0: wb_ready=0, rf_WriteReg=0, rf_DstReg=0, rf_DstData=0, fwd_hit*=0, fwd_data*=0, count=0.
- Handshake: wb_ready = rst & (count != DEPTH). Transfer occurs on a rising edge when wb_valid & wb_ready.
- wb_ready does not look ahead at a same-cycle dequeue: when full, input is refused even if a drain occurs that cycle.
- R0 drop: if DROP_R0=1 and wb_reg=0, the transfer completes (ready honoured) but nothing is enqueued and count is unchanged.
- Drain: rf_WriteReg = (count!=0) & !rf_stall. rf_DstReg and rf_DstData come from the head entry and are driven from flops only.
- The register file captures the write on the same edge that pops the head.
- Empty buffer: rf_DstReg=0, rf_DstData=0.
- Latency: an entry accepted at edge N is presented on the rf_* outputs after edge N (if it is the head) and written at edge N+1.
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO. Multiple entries to the same register are written oldest first.
- Forwarding: combinational search over valid entries.
  - fwd_hitK=1 if any valid entry has reg == rd_regK.
  - fwd_dataK = data of the youngest matching entry (closest to tail), otherwise 16'h0000.
  - The head entry is included until it pops. After the pop the register file holds the value, so there is no coverage gap.
  - An incoming wb_* request in the same cycle is not forwarded.
  - rd_regK=0 with DROP_R0=1 never hits.
- count is a registered value, reflecting state after the last edge.

Decomposition:
- Shared package holds REG_ID_W=4, DATA_W=16, and an entry typedef {reg id, data}.
- One sub-module, wb_fwd_match: takes the entry array, valid mask, head pointer and a register id, and returns hit plus youngest data. It is instantiated twice, once per read port.
- FIFO storage and pointers are written inline.

Test Plan:
1. rst=0 for 3 cycles with wb_valid=1 -> wb_ready=0, rf_WriteReg=0, count=0. After releasing rst: wb_ready=1 next cycle.
2. Write reg3=0xBEEF, rf_stall=0, rd_reg1=3 -> next cycle rf_WriteReg=1, rf_DstReg=3, rf_DstData=0xBEEF, fwd_hit1=1, fwd_data1=0xBEEF. Following cycle rf_WriteReg=0, fwd_hit1=0, count=0.
3. rf_stall=1, write reg5=0x1111 then reg5=0x2222, rd_reg2=5 -> fwd_data2=0x2222, count=2. Drop rf_stall -> writes 0x1111 then 0x2222 on consecutive cycles.
4. rf_stall=1, enqueue 4 entries -> count=4, wb_ready=0, 5th request held. Release stall for one cycle -> count=3, wb_ready=1, and the held request is accepted on the next edge.
5. DROP_R0=1, write reg0=0xFFFF -> handshake completes, count stays 0, rf_WriteReg stays 0. rd_reg1=0 gives fwd_hit1=0, fwd_data1=0.
6. rf_stall=1 with 3 entries queued, pulse rst low mid-cycle -> count=0 and all outputs 0 immediately. After release with rf_stall=0, no register file write occurs.
